commit_trace_buffer: RTL and testbench

- Synthesizable, parametrised successor to the phase-2 bench trace/log monitor.
- Taps the CPU's writeback and memory-stage commit signals every cycle and packs each active cycle into one record.
- Records go into a circular buffer that is drained through a valid/ready port.
- Keeps saturating cycle and instruction counters, and has a configurable watchdog timeout and halt freeze, so run statistics are available on-chip as well as in simulation.

---
 rtl/commit_trace_pkg.sv | 58 +++++
 rtl/commit_trace_buffer_fifo.sv | 96 +++++++++
 rtl/commit_trace_buffer.sv | 178 +++++++++++++++++
 tb/tb_commit_trace_buffer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/commit_trace_pkg.sv
// -----------------------------------------------------------------------------
// commit_trace_pkg
// Shared definitions for the commit trace buffer: record width, flag bit
// positions inside the flag nibble, record field offsets/widths, the capture
// state encoding and a helper that packs one commit record.
// -----------------------------------------------------------------------------
package commit_trace_pkg;

   localparam int REC_W     = 72;

   // Bit positions inside the 4-bit flag nibble {H,W,L,R}
   localparam int FLAG_H    = 3;
   localparam int FLAG_W    = 2;
   localparam int FLAG_L    = 1;
   localparam int FLAG_R    = 0;

   // Record field placement (LSB offset and width)
   localparam int FLAGS_LSB = 68;
   localparam int FLAGS_W   = 4;
   localparam int PC_LSB    = 52;
   localparam int PC_W      = 16;
   localparam int RD_LSB    = 48;
   localparam int RD_W      = 4;
   localparam int RDATA_LSB = 32;
   localparam int RDATA_W   = 16;
   localparam int MADDR_LSB = 16;
   localparam int MADDR_W   = 16;
   localparam int MDATA_LSB = 0;
   localparam int MDATA_W   = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_HALTED  = 2'd2,
      ST_TIMEOUT = 2'd3
   } trace_state_e;

   // Places each field at its fixed offset; callers zero fields whose flag is clear
   function automatic logic [REC_W-1:0] pack_record(
      input logic [FLAGS_W-1:0] flags,
      input logic [PC_W-1:0]    pc,
      input logic [RD_W-1:0]    rd,
      input logic [RDATA_W-1:0] rdata,
      input logic [MADDR_W-1:0] maddr,
      input logic [MDATA_W-1:0] mdata
   );
      logic [REC_W-1:0] rec;
      rec = {REC_W{1'b0}};
      rec[FLAGS_LSB +: FLAGS_W] = flags;
      rec[PC_LSB    +: PC_W]    = pc;
      rec[RD_LSB    +: RD_W]    = rd;
      rec[RDATA_LSB +: RDATA_W] = rdata;
      rec[MADDR_LSB +: MADDR_W] = maddr;
      rec[MDATA_LSB +: MDATA_W] = mdata;
      return rec;
   endfunction

endpackage

// File: rtl/commit_trace_buffer_fifo.sv
// -----------------------------------------------------------------------------
// trace_fifo
// Circular record buffer with occupancy tracking and a selectable full policy
// (drop newest, or evict oldest when OVERWRITE != 0).
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   push_i      write data_i this cycle
//   pop_i       consumer accepts head (ignored when empty)
//   data_i      record to store
//   valid_o     buffer not empty
//   data_o      head record (zero when empty), combinational read
//   count_o     entries held, 0..DEPTH
//   ovf_o       single-cycle pulse: a record was dropped or evicted
// -----------------------------------------------------------------------------
module trace_fifo #(
   parameter int DEPTH     = 16,
   parameter int W         = 72,
   parameter int OVERWRITE = 0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic [W-1:0]           data_i,
   output logic                   valid_o,
   output logic [W-1:0]           data_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   ovf_o
);

   localparam int             AW        = $clog2(DEPTH);
   localparam logic [AW:0]    DEPTH_VAL = (AW+1)'(DEPTH);
   localparam logic [AW-1:0]  PTR_ONE   = AW'(1'b1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] head_q, head_d;
   logic [AW-1:0] tail_q, tail_d;
   logic [AW:0]   count_q, count_d;
   logic          empty_s, full_s, do_pop_s, do_write_s, evict_s, adv_head_s;

   // Next-state for pointers/occupancy and the full-buffer policy decision
   always_comb begin
      empty_s    = (count_q == {(AW+1){1'b0}});
      full_s     = (count_q == DEPTH_VAL);
      do_pop_s   = pop_i & ~empty_s;
      ovf_o      = 1'b0;
      do_write_s = 1'b0;
      evict_s    = 1'b0;
      // A simultaneous pop frees a slot, so only a push without pop overflows
      if (push_i && full_s && !do_pop_s) begin
         ovf_o = 1'b1;
         if (OVERWRITE != 0) begin
            do_write_s = 1'b1;
            evict_s    = 1'b1;
         end else begin
            do_write_s = 1'b0;
            evict_s    = 1'b0;
         end
      end else begin
         do_write_s = push_i;
      end
      adv_head_s = do_pop_s | evict_s;
      head_d     = adv_head_s ? (head_q + PTR_ONE) : head_q;
      tail_d     = do_write_s ? (tail_q + PTR_ONE) : tail_q;
      case ({do_write_s, adv_head_s})
         2'b10:   count_d = count_q + (AW+1)'(1'b1);
         2'b01:   count_d = count_q - (AW+1)'(1'b1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_q  <= {AW{1'b0}};
         tail_q  <= {AW{1'b0}};
         count_q <= {(AW+1){1'b0}};
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage array; contents need no reset because occupancy gates every read
   always_ff @(posedge clk) begin
      if (do_write_s) begin
         mem_q[tail_q] <= data_i;
      end
   end

   assign valid_o = ~empty_s;
   assign data_o  = empty_s ? {W{1'b0}} : mem_q[head_q];
   assign count_o = count_q;

endmodule

// File: rtl/commit_trace_buffer.sv
// -----------------------------------------------------------------------------
// commit_trace_buffer
// Captures CPU writeback / memory-stage commit activity into 72-bit records,
// buffers them for valid/ready draining, and keeps saturating cycle and
// instruction counters with a halt freeze and a cycle watchdog.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   enable                capture enable (IDLE <-> CAPTURE)
//   pc, reg_*, mem_*, hlt commit taps from the CPU pipeline
//   rd_valid/rd_ready     drain handshake, rd_record is the head record
//   occupancy             entries held in the buffer
//   cycle_count           cycles spent in CAPTURE (saturating)
//   inst_count            retired instructions (saturating)
//   overflow/halted/timeout sticky status flags
// -----------------------------------------------------------------------------
module commit_trace_buffer
   import commit_trace_pkg::*;
#(
   parameter int DEPTH     = 16,
   parameter int CNT_W     = 32,
   parameter int TIMEOUT   = 100000,
   parameter int OVERWRITE = 0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic [15:0]            pc,
   input  logic                   reg_write_en,
   input  logic [3:0]             reg_rd,
   input  logic [15:0]            reg_data,
   input  logic                   mem_read_en,
   input  logic                   mem_write_en,
   input  logic [15:0]            mem_addr,
   input  logic [15:0]            mem_wdata,
   input  logic [15:0]            mem_rdata,
   input  logic                   hlt,
   output logic                   rd_valid,
   input  logic                   rd_ready,
   output logic [71:0]            rd_record,
   output logic [$clog2(DEPTH):0] occupancy,
   output logic [CNT_W-1:0]       cycle_count,
   output logic [CNT_W-1:0]       inst_count,
   output logic                   overflow,
   output logic                   halted,
   output logic                   timeout
);

   localparam logic [CNT_W:0]   TIMEOUT_VAL = (CNT_W+1)'(TIMEOUT);
   localparam bit               WDOG_EN     = (TIMEOUT != 32'sd0);
   localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1'b1);

   trace_state_e     state_q;
   logic [CNT_W-1:0] cycle_q, cycle_d;
   logic [CNT_W-1:0] inst_q, inst_d;
   logic             halted_q, timeout_q, overflow_q;
   logic             in_capture_s, ev_r_s, ev_w_s, ev_l_s, ev_h_s;
   logic             push_s, wdog_hit_s, fifo_ovf_s;
   logic [3:0]       flags_s;
   logic [REC_W-1:0] record_s;

   // Event decode and record packing; a store takes priority over a load
   always_comb begin
      ev_r_s                = reg_write_en;
      ev_w_s                = mem_write_en;
      ev_l_s                = mem_read_en & ~mem_write_en;
      ev_h_s                = hlt;
      flags_s               = 4'b0000;
      flags_s[FLAG_H]       = ev_h_s;
      flags_s[FLAG_W]       = ev_w_s;
      flags_s[FLAG_L]       = ev_l_s;
      flags_s[FLAG_R]       = ev_r_s;
      in_capture_s          = (state_q == ST_CAPTURE);
      push_s                = in_capture_s & (|flags_s);
      record_s = pack_record(flags_s, pc,
                             ev_r_s ? reg_rd : 4'h0,
                             ev_r_s ? reg_data : 16'h0000,
                             (ev_w_s | ev_l_s) ? mem_addr : 16'h0000,
                             ev_w_s ? mem_wdata : (ev_l_s ? mem_rdata : 16'h0000));
   end

   // Watchdog compares one bit wider so cycle_count+1 cannot wrap to a false hit
   always_comb begin
      if (WDOG_EN) begin
         wdog_hit_s = (({1'b0, cycle_q} + {{CNT_W{1'b0}}, 1'b1}) == TIMEOUT_VAL);
      end else begin
         wdog_hit_s = 1'b0;
      end
   end

   // Saturating counter next-state; counters only move while capturing
   always_comb begin
      cycle_d = cycle_q;
      inst_d  = inst_q;
      if (in_capture_s) begin
         if (cycle_q != CNT_MAX) begin
            cycle_d = cycle_q + CNT_ONE;
         end else begin
            cycle_d = cycle_q;
         end
         if ((ev_h_s | ev_r_s | ev_w_s) && (inst_q != CNT_MAX)) begin
            inst_d = inst_q + CNT_ONE;
         end else begin
            inst_d = inst_q;
         end
      end else begin
         cycle_d = cycle_q;
         inst_d  = inst_q;
      end
   end

   // Capture FSM with its sticky terminal-state flags; halt outranks watchdog
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         halted_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (enable) begin
                  state_q <= ST_CAPTURE;
               end
            end
            ST_CAPTURE: begin
               if (ev_h_s) begin
                  state_q  <= ST_HALTED;
                  halted_q <= 1'b1;
               end else if (wdog_hit_s) begin
                  state_q   <= ST_TIMEOUT;
                  timeout_q <= 1'b1;
               end else if (!enable) begin
                  state_q <= ST_IDLE;
               end
            end
            ST_HALTED:  state_q <= ST_HALTED;
            ST_TIMEOUT: state_q <= ST_TIMEOUT;
            default:    state_q <= ST_IDLE;
         endcase
      end
   end

   // Counter and sticky overflow registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cycle_q    <= {CNT_W{1'b0}};
         inst_q     <= {CNT_W{1'b0}};
         overflow_q <= 1'b0;
      end else begin
         cycle_q    <= cycle_d;
         inst_q     <= inst_d;
         overflow_q <= overflow_q | fifo_ovf_s;
      end
   end

   trace_fifo #(
      .DEPTH     (DEPTH),
      .W         (REC_W),
      .OVERWRITE (OVERWRITE)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push_s),
      .pop_i   (rd_ready),
      .data_i  (record_s),
      .valid_o (rd_valid),
      .data_o  (rd_record),
      .count_o (occupancy),
      .ovf_o   (fifo_ovf_s)
   );

   assign cycle_count = cycle_q;
   assign inst_count  = inst_q;
   assign overflow    = overflow_q;
   assign halted      = halted_q;
   assign timeout     = timeout_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
module tb_commit_trace_buffer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en0, en1, en2;
   logic        rdy0, rdy1, rdy2;
   logic [15:0] pc;
   logic        reg_write_en;
   logic [3:0]  reg_rd;
   logic [15:0] reg_data;
   logic        mem_read_en, mem_write_en;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        hlt;

   logic        v0, v1, v2;
   logic [71:0] rec0, rec1, rec2;
   logic [2:0]  occ0, occ1, occ2;
   logic [31:0] cyc0, inst0, cyc2, inst2;
   logic [2:0]  cyc1, inst1;
   logic        ovf0, hlt0, to0, ovf1, hlt1, to1, ovf2, hlt2, to2;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   // dut0: drop policy, no watchdog
   commit_trace_buffer #(.DEPTH(4), .CNT_W(32), .TIMEOUT(0), .OVERWRITE(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .enable(en0), .pc(pc), .reg_write_en(reg_write_en),
      .reg_rd(reg_rd), .reg_data(reg_data), .mem_read_en(mem_read_en),
      .mem_write_en(mem_write_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .hlt(hlt), .rd_valid(v0), .rd_ready(rdy0),
      .rd_record(rec0), .occupancy(occ0), .cycle_count(cyc0), .inst_count(inst0),
      .overflow(ovf0), .halted(hlt0), .timeout(to0));

   // dut1: evict policy, 3-bit counters for saturation
   commit_trace_buffer #(.DEPTH(4), .CNT_W(3), .TIMEOUT(0), .OVERWRITE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .enable(en1), .pc(pc), .reg_write_en(reg_write_en),
      .reg_rd(reg_rd), .reg_data(reg_data), .mem_read_en(mem_read_en),
      .mem_write_en(mem_write_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .hlt(hlt), .rd_valid(v1), .rd_ready(rdy1),
      .rd_record(rec1), .occupancy(occ1), .cycle_count(cyc1), .inst_count(inst1),
      .overflow(ovf1), .halted(hlt1), .timeout(to1));

   // dut2: watchdog at 50 cycles
   commit_trace_buffer #(.DEPTH(4), .CNT_W(32), .TIMEOUT(50), .OVERWRITE(0)) dut2 (
      .clk(clk), .rst_n(rst_n), .enable(en2), .pc(pc), .reg_write_en(reg_write_en),
      .reg_rd(reg_rd), .reg_data(reg_data), .mem_read_en(mem_read_en),
      .mem_write_en(mem_write_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .hlt(hlt), .rd_valid(v2), .rd_ready(rdy2),
      .rd_record(rec2), .occupancy(occ2), .cycle_count(cyc2), .inst_count(inst2),
      .overflow(ovf2), .halted(hlt2), .timeout(to2));

   task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ev();
      pc           = 16'h0000;
      reg_write_en = 1'b0;
      reg_rd       = 4'h0;
      reg_data     = 16'h0000;
      mem_read_en  = 1'b0;
      mem_write_en = 1'b0;
      mem_addr     = 16'h0000;
      mem_wdata    = 16'h0000;
      mem_rdata    = 16'h0000;
      hlt          = 1'b0;
   endtask

   // Register-write event number k: pc=k, rd=k[3:0], data=0x1000+k
   task automatic set_r(input int k);
      clear_ev();
      pc           = 16'(k);
      reg_write_en = 1'b1;
      reg_rd       = 4'(k);
      reg_data     = 16'h1000 + 16'(k);
   endtask

   function automatic logic [71:0] exp_rec(input int k);
      logic [15:0] kk;
      kk = 16'(k);
      return {4'b0001, kk, kk[3:0], 16'h1000 + kk, 32'h0000_0000};
   endfunction

   task automatic do_reset();
      en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
      rdy0 = 1'b0; rdy1 = 1'b0; rdy2 = 1'b0;
      clear_ev();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic drain(input int d, input int first, input int n);
      for (int i = 0; i < n; i++) begin
         check_eq($sformatf("drain%0d_rec%0d", d, first + i), (d == 0) ? rec0 : rec1,
                  exp_rec(first + i));
         if (d == 0) rdy0 = 1'b1;
         else        rdy1 = 1'b1;
         tick();
         rdy0 = 1'b0;
         rdy1 = 1'b0;
      end
   endtask

   initial begin
      // ---------------- reset state ----------------
      do_reset();
      check_eq("rst_valid",  v0,   72'd0);
      check_eq("rst_occ",    occ0, 72'd0);
      check_eq("rst_cycle",  cyc0, 72'd0);
      check_eq("rst_inst",   inst0, 72'd0);
      check_eq("rst_flags",  {ovf0, hlt0, to0, ovf1, hlt1, to1}, 72'd0);
      check_eq("rst_record", rec0, 72'd0);

      // ---------------- basic record, write-wins, load-only ----------------
      en0 = 1'b1;
      tick();
      check_eq("idle_no_count", cyc0, 72'd0);
      pc = 16'h0010; reg_write_en = 1'b1; reg_rd = 4'd3; reg_data = 16'h1234;
      tick();
      check_eq("basic_valid",  v0, 72'd1);
      check_eq("basic_record", rec0, {4'b0001, 16'h0010, 4'h3, 16'h1234, 16'h0000, 16'h0000});
      check_eq("basic_inst",   inst0, 72'd1);
      check_eq("basic_cycle",  cyc0, 72'd1);
      clear_ev();
      pc = 16'h0011; mem_read_en = 1'b1; mem_write_en = 1'b1;
      mem_addr = 16'h0040; mem_wdata = 16'hBEEF; mem_rdata = 16'h5555;
      tick();
      check_eq("store_inst", inst0, 72'd2);
      check_eq("store_occ",  occ0, 72'd2);
      clear_ev();
      pc = 16'h0012; mem_read_en = 1'b1; mem_addr = 16'h0044; mem_rdata = 16'hCAFE;
      mem_wdata = 16'h7777; reg_rd = 4'h7; reg_data = 16'h9999;
      tick();
      check_eq("load_no_inst", inst0, 72'd2);
      check_eq("load_occ",     occ0, 72'd3);
      clear_ev();
      tick();
      check_eq("quiet_no_push", occ0, 72'd3);
      check_eq("quiet_cycle",   cyc0, 72'd4);
      en0 = 1'b0;
      check_eq("head_rec1", rec0, {4'b0001, 16'h0010, 4'h3, 16'h1234, 16'h0000, 16'h0000});
      rdy0 = 1'b1;
      tick();
      check_eq("head_rec2", rec0, {4'b0100, 16'h0011, 4'h0, 16'h0000, 16'h0040, 16'hBEEF});
      tick();
      check_eq("head_rec3", rec0, {4'b0010, 16'h0012, 4'h0, 16'h0000, 16'h0044, 16'hCAFE});
      tick();
      check_eq("empty_valid",  v0, 72'd0);
      check_eq("empty_record", rec0, 72'd0);
      tick();
      check_eq("empty_pop_ignored", occ0, 72'd0);
      rdy0 = 1'b0;

      // ---------------- full, drop policy ----------------
      do_reset();
      en0 = 1'b1;
      tick();
      for (int k = 1; k <= 6; k++) begin
         set_r(k);
         tick();
      end
      clear_ev();
      check_eq("drop_occ", occ0, 72'd4);
      check_eq("drop_ovf", ovf0, 72'd1);
      drain(0, 1, 4);
      check_eq("drop_drained", v0, 72'd0);

      do_reset();
      en0 = 1'b1;
      tick();
      for (int k = 1; k <= 4; k++) begin
         set_r(k);
         tick();
      end
      check_eq("fill_occ", occ0, 72'd4);
      set_r(5);
      rdy0 = 1'b1;
      tick();
      rdy0 = 1'b0;
      clear_ev();
      check_eq("pushpop_occ", occ0, 72'd4);
      check_eq("pushpop_ovf", ovf0, 72'd0);
      drain(0, 2, 4);

      // ---------------- full, evict policy + saturation ----------------
      do_reset();
      en1 = 1'b1;
      tick();
      for (int k = 1; k <= 6; k++) begin
         set_r(k);
         tick();
      end
      clear_ev();
      check_eq("evict_occ",  occ1, 72'd4);
      check_eq("evict_ovf",  ovf1, 72'd1);
      check_eq("evict_inst", inst1, 72'd6);
      check_eq("evict_cycle", cyc1, 72'd6);
      drain(1, 3, 4);
      check_eq("cycle_sat", cyc1, 72'd7);
      set_r(7);
      tick();
      set_r(8);
      tick();
      clear_ev();
      check_eq("inst_sat", inst1, 72'd7);

      // ---------------- halt freeze ----------------
      do_reset();
      en0 = 1'b1;
      tick();
      for (int c = 1; c <= 19; c++) tick();
      pc = 16'h0020; hlt = 1'b1;
      tick();
      clear_ev();
      check_eq("halt_flag",   hlt0, 72'd1);
      check_eq("halt_cycle",  cyc0, 72'd20);
      check_eq("halt_inst",   inst0, 72'd1);
      check_eq("halt_record", rec0, {4'b1000, 16'h0020, 52'd0});
      for (int k = 1; k <= 3; k++) begin
         set_r(k);
         tick();
      end
      clear_ev();
      tick();
      check_eq("halt_no_capture", occ0, 72'd1);
      check_eq("halt_cycle_frozen", cyc0, 72'd20);
      check_eq("halt_inst_frozen",  inst0, 72'd1);
      check_eq("wdog_disabled", to0, 72'd0);
      rdy0 = 1'b1;
      tick();
      rdy0 = 1'b0;
      check_eq("drain_after_halt", v0, 72'd0);

      // ---------------- watchdog ----------------
      do_reset();
      en2 = 1'b1;
      tick();
      for (int c = 1; c <= 49; c++) tick();
      check_eq("wdog_before", to2, 72'd0);
      check_eq("wdog_cycle49", cyc2, 72'd49);
      tick();
      check_eq("wdog_fired", to2, 72'd1);
      check_eq("wdog_cycle50", cyc2, 72'd50);
      tick(); tick(); tick();
      check_eq("wdog_frozen", cyc2, 72'd50);
      check_eq("wdog_empty", {v2, occ2, rec2}, 76'd0);
      check_eq("wdog_other", {inst2, ovf2, hlt2}, 72'd0);

      // ---------------- mid-run reset ----------------
      do_reset();
      en0 = 1'b1;
      tick();
      for (int k = 1; k <= 3; k++) begin
         set_r(k);
         tick();
      end
      clear_ev();
      check_eq("pre_reset_occ", occ0, 72'd3);
      en0 = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_eq("midrst_buf",   {v0, occ0, rec0}, 76'd0);
      check_eq("midrst_cnt",   {cyc0, inst0}, 72'd0);
      check_eq("midrst_flags", {ovf0, hlt0, to0}, 72'd0);
      en0 = 1'b1;
      tick();
      set_r(9);
      tick();
      clear_ev();
      check_eq("restart_occ",    occ0, 72'd1);
      check_eq("restart_record", rec0, exp_rec(9));
      check_eq("restart_inst",   inst0, 72'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
